// File: rtl/segment_page_ctrl_pkg.sv
// Shared display definitions: page geometry, data width and the page-to-slice mapping.
package segment_page_ctrl_pkg;
   localparam int PAGE_COUNT = 8;
   localparam int PAGE_W     = 4;
   localparam int DATA_W     = 128;
   localparam int SLICE_W    = 16;

   typedef logic [PAGE_W-1:0] page_t;
   typedef logic [DATA_W-1:0] word_t;

   // Page 0 shows bits 127:112, page 7 shows bits 15:0.
   function automatic logic [SLICE_W-1:0] page_slice(word_t w, page_t p);
      word_t sh;
      sh = w << {p[2:0], 4'b0000};
      return sh[DATA_W-1 -: SLICE_W];
   endfunction
endpackage

// File: rtl/segment_page_ctrl_if.sv
// Result handshake bus between the AES core (master) and the page controller (slave).
interface segment_page_ctrl_if;
   import segment_page_ctrl_pkg::*;

   logic  result_valid;
   word_t result_data;
   logic  result_ready;

   modport master (output result_valid, output result_data, input result_ready);
   modport slave  (input result_valid, input result_data, output result_ready);
endinterface

// File: rtl/segment_page_ctrl_button.sv
// Two-flop synchronizer plus stable-level debouncer with a registered rising-edge pulse.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise_pulse
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             raw_meta;
   logic             raw_s;
   logic [CNT_W-1:0] cnt;

   // Synchronize the raw input, then accept a new level only after it has held long enough.
   always_ff @(posedge clk) begin
      if (rst) begin
         raw_meta   <= 1'b0;
         raw_s      <= 1'b0;
         level      <= 1'b0;
         cnt        <= '0;
         rise_pulse <= 1'b0;
      end else begin
         raw_meta   <= raw;
         raw_s      <= raw_meta;
         rise_pulse <= 1'b0;
         if (raw_s != level) begin
            if (cnt == CNT_LAST) begin
               level      <= raw_s;
               cnt        <= '0;
               rise_pulse <= raw_s;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end
endmodule

// File: rtl/segment_page_ctrl.sv
// Captures AES results, holds them for display and steps the 16-bit page window.
module segment_page_ctrl
   import segment_page_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SCROLL_CYCLES   = 100_000_000
) (
   input  logic                clk,
   input  logic                rst,
   segment_page_ctrl_if.slave  result,
   input  logic                freeze,
   input  logic                btn_next,
   input  logic                auto_en,
   output page_t               page,
   output word_t               data,
   output logic                fresh
);
   localparam int SCR_W = $clog2(SCROLL_CYCLES);
   localparam logic [SCR_W-1:0] SCR_LAST  = SCR_W'(SCROLL_CYCLES - 1);
   localparam page_t            PAGE_LAST = page_t'(PAGE_COUNT - 1);

   logic             freeze_meta, freeze_s;
   logic             auto_meta, auto_s;
   logic             press;
   logic             btn_level;
   logic [SCR_W-1:0] scroll_cnt;
   logic             tick;
   logic             capture;
   logic             advance;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk        (clk),
      .rst        (rst),
      .raw        (btn_next),
      .level      (btn_level),
      .rise_pulse (press)
   );

   assign capture = result.result_valid & result.result_ready;
   assign tick    = auto_s & (scroll_cnt == SCR_LAST);
   assign advance = press | tick;

   // Synchronize the slide switches; ready is a registered copy of the inverted freeze level.
   always_ff @(posedge clk) begin
      if (rst) begin
         freeze_meta         <= 1'b0;
         freeze_s            <= 1'b0;
         auto_meta           <= 1'b0;
         auto_s              <= 1'b0;
         result.result_ready <= 1'b0;
      end else begin
         freeze_meta         <= freeze;
         freeze_s            <= freeze_meta;
         auto_meta           <= auto_en;
         auto_s              <= auto_meta;
         result.result_ready <= ~freeze_s;
      end
   end

   // Dwell timer: any page change (tick, press or capture) restarts the interval.
   always_ff @(posedge clk) begin
      if (rst) begin
         scroll_cnt <= '0;
      end else if (!auto_s || capture || press || tick) begin
         scroll_cnt <= '0;
      end else begin
         scroll_cnt <= scroll_cnt + 1'b1;
      end
   end

   // Capture wins over a same-cycle advance; fresh clears once all pages have been shown.
   always_ff @(posedge clk) begin
      if (rst) begin
         data  <= '0;
         page  <= '0;
         fresh <= 1'b0;
      end else if (capture) begin
         data  <= result.result_data;
         page  <= '0;
         fresh <= 1'b1;
      end else if (advance) begin
         if (page == PAGE_LAST) begin
            page  <= '0;
            fresh <= 1'b0;
         end else begin
            page <= page + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_segment_page_ctrl.sv
// Directed and randomized checks of segment_page_ctrl with short debounce/scroll settings.
module tb_segment_page_ctrl;
   localparam int DB  = 4;
   localparam int SCR = 10;

   logic clk = 1'b0;
   logic rst;
   logic freeze;
   logic btn_next;
   logic auto_en;
   logic [3:0]   page;
   logic [127:0] data;
   logic         fresh;

   int vectors = 0;
   int errors  = 0;

   // Reference state: displayed page, held word and fresh flag.
   int           m_page;
   logic [127:0] m_data;
   logic         m_fresh;

   segment_page_ctrl_if bus();

   segment_page_ctrl #(.DEBOUNCE_CYCLES(DB), .SCROLL_CYCLES(SCR)) dut (
      .clk      (clk),
      .rst      (rst),
      .result   (bus),
      .freeze   (freeze),
      .btn_next (btn_next),
      .auto_en  (auto_en),
      .page     (page),
      .data     (data),
      .fresh    (fresh)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Clean press: high 8 cycles, then low long enough for the release to settle.
   task automatic press_btn();
      btn_next = 1'b1;
      step(8);
      btn_next = 1'b0;
      step(10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [127:0] w;
      rst = 1'b1; freeze = 1'b0; btn_next = 1'b0; auto_en = 1'b0;
      bus.result_valid = 1'b0;
      bus.result_data  = '0;
      step(3);
      chk("rst_page",  page,  0);
      chk("rst_data",  data,  0);
      chk("rst_fresh", fresh, 0);
      chk("rst_ready", bus.result_ready, 0);
      rst = 1'b0;
      n = 0;
      while (bus.result_ready !== 1'b1 && n < 3) begin
         step();
         n++;
      end
      chk("ready_after_reset", bus.result_ready, 1);

      // Capture
      w = 128'h0123456789abcdef0123456789abcdef;
      bus.result_valid = 1'b1;
      bus.result_data  = w;
      step();
      bus.result_valid = 1'b0;
      chk("cap_data",  data,  w);
      chk("cap_page",  page,  0);
      chk("cap_fresh", fresh, 1);

      // Freeze refuses new results
      freeze = 1'b1;
      step(2);
      chk("freeze_ready_2", bus.result_ready, 1);
      step();
      chk("freeze_ready_3", bus.result_ready, 0);
      bus.result_valid = 1'b1;
      bus.result_data  = {128{1'b1}};
      step(4);
      bus.result_valid = 1'b0;
      chk("freeze_data", data, w);
      chk("freeze_fresh", fresh, 1);
      freeze = 1'b0;
      step(3);
      chk("unfreeze_ready", bus.result_ready, 1);

      // Glitch ignored
      btn_next = 1'b1;
      step(2);
      btn_next = 1'b0;
      step(10);
      chk("glitch_page", page, 0);

      // Press latency: page changes on the 7th edge after the rise
      btn_next = 1'b1;
      step(6);
      chk("press_edge6", page, 0);
      step();
      chk("press_edge7", page, 1);
      step();
      btn_next = 1'b0;
      step(10);

      // Walk to the wrap
      for (int i = 0; i < 6; i++) press_btn();
      chk("page7", page, 7);
      chk("page7_fresh", fresh, 1);
      press_btn();
      chk("wrap_page", page, 0);
      chk("wrap_fresh", fresh, 0);

      // Auto-scroll: first tick 2 sync edges + 10
      auto_en = 1'b1;
      step(11);
      chk("auto_edge11", page, 0);
      step();
      chk("auto_p1", page, 1);
      step(10);
      chk("auto_p2", page, 2);
      step(10);
      chk("auto_p3", page, 3);
      auto_en = 1'b0;
      step(30);
      chk("auto_off_hold", page, 3);

      // Press mid-interval restarts the dwell
      auto_en = 1'b1;
      step(12);
      chk("auto_p4", page, 4);
      btn_next = 1'b1;
      step(7);
      chk("mid_press", page, 5);
      step();
      btn_next = 1'b0;
      step(2);
      chk("restart_no_old_tick", page, 5);
      step(6);
      chk("restart_edge9", page, 5);
      step();
      chk("restart_edge10", page, 6);

      // Capture on the same edge as a tick
      step(9);
      w = {$urandom, $urandom, $urandom, $urandom};
      bus.result_valid = 1'b1;
      bus.result_data  = w;
      step();
      bus.result_valid = 1'b0;
      chk("coll_page",  page,  0);
      chk("coll_data",  data,  w);
      chk("coll_fresh", fresh, 1);
      step(9);
      chk("coll_dwell9", page, 0);
      step();
      chk("coll_dwell10", page, 1);

      // Reset with page 5, debounce count 2, scroll count 7
      step(40);
      chk("pre_rst_page", page, 5);
      step(3);
      btn_next = 1'b1;
      step(4);
      rst = 1'b1;
      step();
      chk("mid_rst_page",  page,  0);
      chk("mid_rst_data",  data,  0);
      chk("mid_rst_fresh", fresh, 0);
      chk("mid_rst_ready", bus.result_ready, 0);
      rst = 1'b0;
      auto_en = 1'b0;
      step(6);
      chk("post_rst_edge6", page, 0);
      step();
      chk("post_rst_edge7", page, 1);
      chk("post_rst_fresh", fresh, 0);
      chk("post_rst_ready", bus.result_ready, 1);
      btn_next = 1'b0;
      step(10);

      // Randomized sequence against the reference state
      m_page = 1; m_data = '0; m_fresh = 1'b0;
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 2))
            0: begin
               w = {$urandom, $urandom, $urandom, $urandom};
               bus.result_valid = 1'b1;
               bus.result_data  = w;
               step();
               bus.result_valid = 1'b0;
               m_data = w; m_page = 0; m_fresh = 1'b1;
            end
            1: begin
               press_btn();
               if (m_page == 7) begin
                  m_page = 0;
                  m_fresh = 1'b0;
               end else begin
                  m_page = m_page + 1;
               end
            end
            default: begin
               freeze = 1'b1;
               step(3);
               bus.result_valid = 1'b1;
               bus.result_data  = {$urandom, $urandom, $urandom, $urandom};
               step($urandom_range(1, 4));
               bus.result_valid = 1'b0;
               freeze = 1'b0;
               step(3);
            end
         endcase
         chk("rnd_page",  page,  m_page[3:0]);
         chk("rnd_data",  data,  m_data);
         chk("rnd_fresh", fresh, m_fresh);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
